// File: rtl/memoria_arb_pkg.sv
// Shared constants, state encoding and request payload for memoria_arbiter.
package memoria_arb_pkg;

    localparam int unsigned AW                = 5;
    localparam int unsigned DW                = 14;
    localparam int unsigned PROT_BASE_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // One requester's access as seen by the arbiter.
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/memoria_arbiter_if.sv
// Requester handshakes plus the memory-side bus of memoria_arbiter.
interface memoria_arbiter_if;
    import memoria_arb_pkg::*;

    logic          req_a;
    logic          req_b;
    logic          wr_a;
    logic          wr_b;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_a;
    logic [DW-1:0] wdata_b;
    logic          ack_a;
    logic          ack_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          err_b;
    logic          busy;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    // Arbiter side.
    modport slave (
        input  req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b, mem_dout,
        output ack_a, ack_b, rdata_a, rdata_b, err_b, busy,
               mem_en, mem_wr, mem_addr, mem_din
    );

    // Requester / memory side.
    modport master (
        output req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b, mem_dout,
        input  ack_a, ack_b, rdata_a, rdata_b, err_b, busy,
               mem_en, mem_wr, mem_addr, mem_din
    );

endinterface

// File: rtl/memoria_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone eligible port wins, a tie goes to the port not granted last.
module rr_arbiter2
    import memoria_arb_pkg::*;
(
    input  logic eligible_a,
    input  logic eligible_b,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_port
);

    // Combinational grant selection.
    always_comb begin
        gnt_valid = eligible_a | eligible_b;
        gnt_port  = PORT_A;
        if (eligible_a && eligible_b) begin
            gnt_port = ~last_gnt;
        end else if (eligible_b) begin
            gnt_port = PORT_B;
        end
    end

endmodule

// File: rtl/memoria_arbiter.sv
// Round-robin sequencer sharing the 32x14 single-port memory between ports A and B.
// Optional ARB_WR_PROTECT_EN: port-B writes at or above PROT_BASE are acked with err_b
// and never reach the memory.
module memoria_arbiter
    import memoria_arb_pkg::*;
`ifdef ARB_WR_PROTECT_EN
#(
    parameter int unsigned PROT_BASE = PROT_BASE_DEFAULT
)
`endif
(
    input logic              clk,
    input logic              rst_n,
    memoria_arbiter_if.slave bus
);

    arb_state_t    state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          gnt_q, gnt_d;
    logic          op_wr_q, op_wr_d;
    logic          reject_q, reject_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic          err_b_q, err_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d;
    logic [DW-1:0] rdata_b_q, rdata_b_d;
    logic          busy_q, busy_d;

    logic          eligible_a_c;
    logic          eligible_b_c;
    logic          gnt_valid_c;
    logic          gnt_port_c;
    logic          reject_c;
    arb_req_t      req_a_c;
    arb_req_t      req_b_c;
    arb_req_t      sel_c;

    // A port whose ack is high this cycle has already been served; do not grant it again.
    assign eligible_a_c = bus.req_a & ~ack_a_q;
    assign eligible_b_c = bus.req_b & ~ack_b_q;

    assign req_a_c = '{wr: bus.wr_a, addr: bus.addr_a, wdata: bus.wdata_a};
    assign req_b_c = '{wr: bus.wr_b, addr: bus.addr_b, wdata: bus.wdata_b};
    assign sel_c   = (gnt_port_c == PORT_B) ? req_b_c : req_a_c;

    rr_arbiter2 u_rr (
        .eligible_a (eligible_a_c),
        .eligible_b (eligible_b_c),
        .last_gnt   (last_gnt_q),
        .gnt_valid  (gnt_valid_c),
        .gnt_port   (gnt_port_c)
    );

    // Protected-region check for the access about to be granted.
`ifdef ARB_WR_PROTECT_EN
    assign reject_c = (gnt_port_c == PORT_B) && sel_c.wr && (32'(sel_c.addr) >= PROT_BASE);
`else
    assign reject_c = 1'b0;
`endif

    // State and output registers; reset aborts any in-flight access without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= PORT_B;
            gnt_q      <= PORT_A;
            op_wr_q    <= 1'b0;
            reject_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            op_wr_q    <= op_wr_d;
            reject_q   <= reject_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            err_b_q    <= err_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and next-output logic for IDLE -> ISSUE -> CAPTURE.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        op_wr_d    = op_wr_q;
        reject_d   = reject_q;
        mem_en_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        err_b_d    = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        busy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid_c) begin
                    state_d    = ISSUE;
                    gnt_d      = gnt_port_c;
                    last_gnt_d = gnt_port_c;
                    op_wr_d    = sel_c.wr;
                    reject_d   = reject_c;
                    mem_en_d   = ~reject_c;
                    mem_wr_d   = sel_c.wr & ~reject_c;
                    mem_addr_d = sel_c.addr;
                    mem_din_d  = sel_c.wdata;
                    busy_d     = 1'b1;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
                busy_d  = 1'b1;
            end
            CAPTURE: begin
                state_d = IDLE;
                if (gnt_q == PORT_A) begin
                    ack_a_d = 1'b1;
                    if (!op_wr_q) begin
                        rdata_a_d = bus.mem_dout;
                    end
                end else begin
                    ack_b_d = 1'b1;
                    err_b_d = reject_q;
                    if (!op_wr_q) begin
                        rdata_b_d = bus.mem_dout;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_en   = mem_en_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.ack_a    = ack_a_q;
    assign bus.ack_b    = ack_b_q;
    assign bus.err_b    = err_b_q;
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.busy     = busy_q;

endmodule
